// File: rtl/vga_scan_timing.sv
// Raster timing generator: divides the system clock into a pixel enable and
// scans X/Y over the full frame, producing registered sync/active decodes.
module vga_scan_timing #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset,
  output logic        pix_en,
  output logic [15:0] Xcoordinate,
  output logic [15:0] Ycoordinate,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        line_end,
  output logic        frame_end,
  output logic [7:0]  frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [15:0] X_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] Y_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] HS_FIRST = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_LAST  = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [15:0] VS_FIRST = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_LAST  = 16'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [15:0] H_VIS    = 16'(H_ACTIVE);
  localparam logic [15:0] V_VIS    = 16'(V_ACTIVE);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;
  logic [15:0]      x;
  logic [15:0]      y;
  logic [15:0]      x_next;
  logic [15:0]      y_next;
  logic [7:0]       fcount;
  logic [7:0]       fcount_next;
  logic             hsync_reg;
  logic             vsync_reg;
  logic             active_reg;
  logic             hsync_next;
  logic             vsync_next;
  logic             active_next;

  // Strobes are combinational so they line up with the edge that consumes them.
  assign pix_en      = (div == DIV_LAST) & ~reset;
  assign line_end    = pix_en & (x == X_LAST);
  assign frame_end   = line_end & (y == Y_LAST);
  assign Xcoordinate = x;
  assign Ycoordinate = y;
  assign frame_count = fcount;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign active      = active_reg;

  // Next-state for divider, scan counters and frame counter, plus decodes of next X/Y.
  always_comb begin
    div_next    = div;
    x_next      = x;
    y_next      = y;
    fcount_next = fcount;

    if (div == DIV_LAST) begin
      div_next = {DIV_W{1'b0}};
    end else begin
      div_next = div + DIV_W'(1);
    end

    if (pix_en) begin
      if (x == X_LAST) begin
        x_next = 16'd0;
        if (y == Y_LAST) begin
          y_next      = 16'd0;
          fcount_next = fcount + 8'd1;
        end else begin
          y_next = y + 16'd1;
        end
      end else begin
        x_next = x + 16'd1;
      end
    end else begin
      x_next = x;
    end

    // Decoding the next position keeps the registered syncs aligned with X/Y.
    hsync_next  = ~((x_next >= HS_FIRST) && (x_next <= HS_LAST));
    vsync_next  = ~((y_next >= VS_FIRST) && (y_next <= VS_LAST));
    active_next = (x_next < H_VIS) && (y_next < V_VIS);
  end

  // State and decoded-output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div        <= {DIV_W{1'b0}};
      x          <= 16'd0;
      y          <= 16'd0;
      fcount     <= 8'd0;
      hsync_reg  <= 1'b1;
      vsync_reg  <= 1'b1;
      active_reg <= 1'b1;
    end else begin
      div        <= div_next;
      x          <= x_next;
      y          <= y_next;
      fcount     <= fcount_next;
      hsync_reg  <= hsync_next;
      vsync_reg  <= vsync_next;
      active_reg <= active_next;
    end
  end

endmodule
